// File: rtl/capture_dump_ctrl.sv
// Capture/dump sequencer: decodes UART command bytes, triggers the sampler and
// streams the whole sample memory out through the UART transmitter, one byte per handshake.
module capture_dump_ctrl #(
    parameter int         ADDR_WIDTH = 16,
    parameter logic [7:0] CMD_SAMPLE = 8'h53,
    parameter logic [7:0] CMD_DUMP   = 8'h44,
    parameter logic [7:0] CMD_ABORT  = 8'h41
) (
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic [7:0]            iRx_Data,
    input  logic                  iRx_Done,
    output logic [7:0]            oTx_Data,
    output logic                  oTx_Start,
    input  logic                  iTx_Busy,
    output logic                  oStart_Sampling,
    input  logic                  iSampling_Finished,
    output logic [ADDR_WIDTH-1:0] oAddress,
    input  logic [7:0]            iMem_Data,
    output logic                  oBusy,
    output logic                  oDone
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_SAMPLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT
    } state_e;

    state_e                state_q, state_d;
    logic                  abort_q, abort_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  start_sampling_q, start_sampling_d;
    logic                  done_q, done_d;
    logic                  abort_cmd;

    assign abort_cmd = iRx_Done && (iRx_Data == CMD_ABORT);

    // NOTE: every variable gets its default before the case so no path leaves
    // one unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        state_d          = state_q;
        abort_d          = abort_q;
        addr_d           = addr_q;
        tx_data_d        = tx_data_q;
        done_d           = 1'b0;

        // An abort outside WAIT_SAMPLE only arms the flag; the byte in flight finishes first.
        if (abort_cmd && state_q != S_IDLE) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (iRx_Done && iRx_Data == CMD_SAMPLE) begin
                    state_d = S_ARM;
                end else if (iRx_Done && iRx_Data == CMD_DUMP) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_ARM:         state_d = S_WAIT_SAMPLE;
            S_WAIT_SAMPLE: begin
                if (abort_cmd || abort_q) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end else if (iSampling_Finished) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH:       state_d = S_LOAD;
            S_LOAD: begin
                tx_data_d = iMem_Data;
                state_d   = S_SEND;
            end
            S_SEND:        state_d = S_WAIT_HI;
            S_WAIT_HI:     if (iTx_Busy)  state_d = S_WAIT_LO;
            S_WAIT_LO:     if (!iTx_Busy) state_d = S_NEXT;
            S_NEXT: begin
                if (abort_q || abort_cmd) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end else if (addr_q == '1) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    addr_d  = '0;
                end else begin
                    state_d = S_FETCH;
                    addr_d  = addr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                abort_d = 1'b0;
            end
        endcase

        // Pulses are registered alongside the state they belong to, so each lasts exactly that state.
        start_sampling_d = (state_d == S_ARM);
        tx_start_d       = (state_d == S_SEND);
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    // NOTE: the transmit data register is reset too, because oTx_Data is a
    // visible output that must read zero out of reset.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q          <= S_IDLE;
            abort_q          <= 1'b0;
            addr_q           <= '0;
            tx_data_q        <= '0;
            tx_start_q       <= 1'b0;
            start_sampling_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            abort_q          <= abort_d;
            addr_q           <= addr_d;
            tx_data_q        <= tx_data_d;
            tx_start_q       <= tx_start_d;
            start_sampling_q <= start_sampling_d;
            done_q           <= done_d;
        end
    end

    assign oTx_Data        = tx_data_q;
    assign oTx_Start       = tx_start_q;
    assign oStart_Sampling = start_sampling_q;
    assign oAddress        = addr_q;
    assign oDone           = done_q;
    assign oBusy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Scoreboard bench for capture_dump_ctrl: a RAM and transmitter model drive the DUT,
// expected byte streams are queued at command time and popped by an independent monitor.
module tb_capture_dump_ctrl;

    localparam int         AW         = 6;
    localparam int         N          = 1 << AW;
    localparam logic [7:0] CMD_SAMPLE = 8'h53;
    localparam logic [7:0] CMD_DUMP   = 8'h44;
    localparam logic [7:0] CMD_ABORT  = 8'h41;

    logic          iClock = 1'b0;
    logic          iReset_n;
    logic [7:0]    iRx_Data;
    logic          iRx_Done;
    logic [7:0]    oTx_Data;
    logic          oTx_Start;
    logic          iTx_Busy;
    logic          oStart_Sampling;
    logic          iSampling_Finished;
    logic [AW-1:0] oAddress;
    logic [7:0]    iMem_Data;
    logic          oBusy;
    logic          oDone;

    capture_dump_ctrl #(
        .ADDR_WIDTH(AW), .CMD_SAMPLE(CMD_SAMPLE), .CMD_DUMP(CMD_DUMP), .CMD_ABORT(CMD_ABORT)
    ) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iRx_Data(iRx_Data), .iRx_Done(iRx_Done),
        .oTx_Data(oTx_Data), .oTx_Start(oTx_Start), .iTx_Busy(iTx_Busy),
        .oStart_Sampling(oStart_Sampling), .iSampling_Finished(iSampling_Finished),
        .oAddress(oAddress), .iMem_Data(iMem_Data), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    // Registered RAM, one cycle of read latency.
    logic [7:0] ram [N];
    always @(posedge iClock) iMem_Data <= ram[oAddress];

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    int         tx_count = 0;
    int         done_cnt = 0;
    bit         tx_killed = 1'b0;
    int         busy_min = 10;
    int         busy_max = 10;
    logic       prev_start = 1'b0;
    logic       prev_txs = 1'b0;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every transmitted byte must be the next one the scoreboard expects.
    always @(negedge iClock) begin
        if (iReset_n) begin
            if (oTx_Start) begin
                check("tx_start_width", prev_txs, 0);
                check("tx_queue_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_byte", oTx_Data, exp_q.pop_front());
                tx_count++;
            end
            if (oDone) begin
                check("done_width", prev_done, 0);
                check("done_after_last_byte", exp_q.size(), 0);
                done_cnt++;
            end
            if (oStart_Sampling) check("start_width", prev_start, 0);
        end
        prev_txs   <= oTx_Start;
        prev_done  <= oDone;
        prev_start <= oStart_Sampling;
    end

    // Transmitter model: busy rises the cycle after oTx_Start, data must hold until it falls.
    initial begin : tx_model
        logic [7:0] held;
        bit         bad;
        int         n;
        iTx_Busy = 1'b0;
        forever begin
            @(negedge iClock);
            if (iReset_n && oTx_Start) begin
                held      = oTx_Data;
                bad       = 1'b0;
                tx_killed = 1'b0;
                n         = $urandom_range(busy_max, busy_min);
                @(posedge iClock);
                #1 iTx_Busy = 1'b1;
                repeat (n) begin
                    @(negedge iClock);
                    if (!tx_killed && oTx_Data !== held) bad = 1'b1;
                    @(posedge iClock);
                end
                #1 iTx_Busy = 1'b0;
                if (!tx_killed) check("tx_data_held", bad, 0);
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge iClock);
        #1 iRx_Data = b;
        iRx_Done = 1'b1;
        @(posedge iClock);
        #1 iRx_Done = 1'b0;
        iRx_Data = 8'h00;
    endtask

    task automatic pulse_finished();
        @(posedge iClock);
        #1 iSampling_Finished = 1'b1;
        @(posedge iClock);
        #1 iSampling_Finished = 1'b0;
    endtask

    task automatic wait_first_tx(input string name, input int exp_cyc);
        int c = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge iClock);
            c++;
            if (oTx_Start) break;
        end
        check(name, c, exp_cyc);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge iClock);
            if (!oBusy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
        repeat (2) @(negedge iClock);
    endtask

    task automatic wait_byte_busy(input string name, input int nbytes, input int tc0);
        bit ok = 1'b0;
        for (int i = 0; i < 40 * N; i++) begin
            @(negedge iClock);
            if (tx_count - tc0 == nbytes && iTx_Busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) ram[i] = 8'($urandom);
    endtask

    task automatic push_dump();
        for (int i = 0; i < N; i++) exp_q.push_back(ram[i]);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d0, t0;
        iReset_n = 1'b0;
        iRx_Data = 8'h00;
        iRx_Done = 1'b0;
        iSampling_Finished = 1'b0;
        for (int i = 0; i < N; i++) ram[i] = 8'(i);
        repeat (3) @(posedge iClock);
        #1 iReset_n = 1'b1;

        @(negedge iClock);
        check("rst_tx_data", oTx_Data, 0);
        check("rst_address", oAddress, 0);
        check("rst_tx_start", oTx_Start, 0);
        check("rst_start_sampling", oStart_Sampling, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);

        // Full dump of an index-pattern RAM with a 10-cycle transmitter.
        d0 = done_cnt; t0 = tx_count;
        push_dump();
        send_cmd(CMD_DUMP);
        wait_first_tx("dump_first_latency", 3);
        wait_idle("dump_idle", 40 * N);
        check("dump_done_count", done_cnt - d0, 1);
        check("dump_byte_count", tx_count - t0, N);
        check("dump_addr_after", oAddress, 0);
        check("dump_busy_after", oBusy, 0);

        // Random dumps with random busy times and stray commands mid-dump.
        busy_min = 1; busy_max = 6;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            d0 = done_cnt; t0 = tx_count;
            push_dump();
            send_cmd(CMD_DUMP);
            repeat ($urandom_range(5, 60)) @(posedge iClock);
            send_cmd(CMD_DUMP);
            repeat ($urandom_range(5, 60)) @(posedge iClock);
            send_cmd(8'h00);
            repeat ($urandom_range(5, 60)) @(posedge iClock);
            send_cmd(CMD_SAMPLE);
            wait_idle("rand_dump_idle", 40 * N);
            check("rand_dump_done_count", done_cnt - d0, 1);
            check("rand_dump_byte_count", tx_count - t0, N);
        end

        // Sample then automatic dump.
        busy_min = 3; busy_max = 8;
        fill_random();
        d0 = done_cnt; t0 = tx_count;
        push_dump();
        send_cmd(CMD_SAMPLE);
        @(negedge iClock);
        check("sample_start_pulse", oStart_Sampling, 1);
        @(negedge iClock);
        check("sample_start_drop", oStart_Sampling, 0);
        repeat (100) @(posedge iClock);
        check("sample_no_tx_before_finish", tx_count - t0, 0);
        check("sample_busy_waiting", oBusy, 1);
        pulse_finished();
        wait_first_tx("sample_first_latency", 3);
        wait_idle("sample_idle", 40 * N);
        check("sample_done_count", done_cnt - d0, 1);
        check("sample_byte_count", tx_count - t0, N);

        // Abort while waiting for the sampler; a late finish is ignored.
        d0 = done_cnt; t0 = tx_count;
        send_cmd(CMD_SAMPLE);
        repeat (5) @(posedge iClock);
        send_cmd(CMD_ABORT);
        @(negedge iClock);
        check("abort_wait_idle", oBusy, 0);
        pulse_finished();
        repeat (20) @(negedge iClock);
        check("abort_wait_still_idle", oBusy, 0);
        check("abort_wait_no_tx", tx_count - t0, 0);
        check("abort_wait_no_done", done_cnt - d0, 0);

        // Abort and sampler finish in the same cycle: abort wins.
        send_cmd(CMD_SAMPLE);
        repeat (5) @(posedge iClock);
        @(posedge iClock);
        #1 iRx_Data = CMD_ABORT;
        iRx_Done = 1'b1;
        iSampling_Finished = 1'b1;
        @(posedge iClock);
        #1 iRx_Done = 1'b0;
        iSampling_Finished = 1'b0;
        @(negedge iClock);
        check("abort_vs_finish_idle", oBusy, 0);
        repeat (10) @(negedge iClock);
        check("abort_vs_finish_no_tx", tx_count - t0, 0);

        // Abort while byte 0x10 is on the wire.
        busy_min = 10; busy_max = 10;
        fill_random();
        d0 = done_cnt; t0 = tx_count;
        push_dump();
        send_cmd(CMD_DUMP);
        wait_byte_busy("abort_mid_reach", 17, t0);
        exp_q.delete();
        send_cmd(CMD_ABORT);
        check("abort_mid_byte", oTx_Data, ram[16]);
        wait_idle("abort_mid_idle", 100);
        check("abort_mid_byte_count", tx_count - t0, 17);
        check("abort_mid_no_done", done_cnt - d0, 0);

        // Abort during the last byte suppresses oDone.
        d0 = done_cnt; t0 = tx_count;
        push_dump();
        send_cmd(CMD_DUMP);
        wait_byte_busy("abort_last_reach", N, t0);
        send_cmd(CMD_ABORT);
        wait_idle("abort_last_idle", 100);
        check("abort_last_byte_count", tx_count - t0, N);
        check("abort_last_no_done", done_cnt - d0, 0);

        // Asynchronous reset in WAIT_LO at address 0x23, then a clean restart.
        t0 = tx_count;
        push_dump();
        send_cmd(CMD_DUMP);
        wait_byte_busy("reset_reach", 36, t0);
        @(posedge iClock);
        #1 check("reset_pre_addr", oAddress, 'h23);
        tx_killed = 1'b1;
        iReset_n  = 1'b0;
        exp_q.delete();
        #1;
        check("reset_async_tx_data", oTx_Data, 0);
        check("reset_async_address", oAddress, 0);
        check("reset_async_busy", oBusy, 0);
        check("reset_async_tx_start", oTx_Start, 0);
        check("reset_async_done", oDone, 0);
        repeat (2) @(posedge iClock);
        #1 iReset_n = 1'b1;
        for (int i = 0; i < 50 && iTx_Busy; i++) @(posedge iClock);
        check("reset_tx_released", iTx_Busy, 0);
        fill_random();
        d0 = done_cnt; t0 = tx_count;
        push_dump();
        send_cmd(CMD_DUMP);
        wait_first_tx("restart_latency", 3);
        check("restart_addr", oAddress, 0);
        wait_idle("restart_idle", 40 * N);
        check("restart_done_count", done_cnt - d0, 1);
        check("restart_byte_count", tx_count - t0, N);

        // Stray bytes and sampler finish in IDLE are ignored.
        send_cmd(CMD_ABORT);
        send_cmd(8'h00);
        pulse_finished();
        repeat (3) @(negedge iClock);
        check("idle_ignore_busy", oBusy, 0);
        check("idle_ignore_start", oStart_Sampling, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_dump_ctrl.md
Name: capture_dump_ctrl

Overview:
- Sequencer for the logic-capture path: decodes single-byte commands from the UART receiver, triggers the sampler, then streams the full sample memory out through the UART transmitter, one byte per transmitter handshake.
- Owns the sample-memory read address.
- Shares nothing itself; sits between uart rx/tx, the sampler and the sample RAM.

Parameters:
- ADDR_WIDTH, 16, sample memory address width; a dump covers 2^ADDR_WIDTH bytes.
- CMD_SAMPLE, 8'h53, command: start sampling, then dump automatically.
- CMD_DUMP, 8'h44, command: dump memory without sampling.
- CMD_ABORT, 8'h41, command: abort current operation.

Ports:
- iClock, input, 1, system clock; all logic rising-edge.
- iReset_n, input, 1, asynchronous active-low reset.
- iRx_Data, input, 8, received byte; valid when iRx_Done.
- iRx_Done, input, 1, one-cycle pulse per received byte.
- oTx_Data, output, 8, byte to transmit; held stable from oTx_Start until iTx_Busy falls.
- oTx_Start, output, 1, one-cycle transmit request.
- iTx_Busy, input, 1, transmitter busy; rises within 1 cycle of oTx_Start and falls when the byte is done.
- oStart_Sampling, output, 1, one-cycle pulse to the sampler.
- iSampling_Finished, input, 1, pulse or level from the sampler when capture is complete.
- oAddress, output, ADDR_WIDTH, sample RAM read address.
- iMem_Data, input, 8, RAM read data; registered RAM with 1-cycle latency.
- oBusy, output, 1, high in every state except IDLE.
- oDone, output, 1, one-cycle pulse when a dump completes normally (not on abort).

Behaviour:
- Reset state: state IDLE, abort flag 0, and all outputs 0 (oTx_Data=0, oAddress=0, oTx_Start=0, oStart_Sampling=0, oBusy=0, oDone=0). Reset mid-operation drops everything immediately; no byte is completed.
- IDLE:
  - iRx_Done with CMD_SAMPLE -> ARM.
  - iRx_Done with CMD_DUMP -> FETCH, oAddress=0.
  - Any other byte, including CMD_ABORT, is ignored.
  - iSampling_Finished in IDLE is ignored.
- ARM: oStart_Sampling=1 for exactly this cycle -> WAIT_SAMPLE.
- WAIT_SAMPLE: waits for iSampling_Finished=1, then -> FETCH with oAddress=0.
- FETCH: address presented for 1 cycle -> LOAD.
- LOAD: oTx_Data <= iMem_Data -> SEND.
- SEND: oTx_Start=1 for exactly this cycle -> WAIT_HI.
- WAIT_HI: stays until iTx_Busy=1 -> WAIT_LO. The transmitter contract guarantees this within 1 cycle; no timeout.
- WAIT_LO: stays until iTx_Busy=0 -> NEXT.
- NEXT:
  - If the abort flag is set -> IDLE, flag cleared.
  - Else if oAddress == all-ones -> IDLE with oDone=1 and oAddress wrapped to 0. The last address is transmitted, so exactly 2^ADDR_WIDTH bytes go out.
  - Else oAddress+1 -> FETCH.
- Latency per byte: 4 cycles of overhead plus the transmitter busy time. First oTx_Start is 3 cycles after the CMD_DUMP iRx_Done.
- Abort:
  - CMD_ABORT received while in WAIT_SAMPLE -> IDLE next cycle, no oDone.
  - CMD_ABORT received in any other non-IDLE state sets the abort flag. The byte in flight completes (oTx_Data never changes mid-byte), then NEXT returns to IDLE.
  - Non-abort commands received while oBusy=1 are ignored.
- Simultaneous events:
  - iRx_Done with CMD_ABORT in the same cycle as NEXT: abort wins, no oDone even when on the last address.
  - iRx_Done with CMD_ABORT in the same cycle as iSampling_Finished in WAIT_SAMPLE: abort wins.
- oStart_Sampling, oTx_Start and oDone are never high for more than one consecutive cycle and are registered outputs.
- oAddress changes only in NEXT, at the IDLE->FETCH transition and at reset.

Test Plan:
- Reset with iReset_n=0 mid-WAIT_LO at address 0x0123 -> all outputs 0 and state IDLE asynchronously. After release, a CMD_DUMP restarts at address 0.
- CMD_DUMP (0x44) with RAM[i]=i[7:0] and a transmitter model of 10 busy cycles -> 65536 oTx_Start pulses carrying bytes 0x00,0x01,...,0xFF repeating. The last byte comes from address 0xFFFF, followed by a single oDone pulse; oAddress=0 and oBusy=0 afterwards.
- CMD_SAMPLE (0x53) -> oStart_Sampling pulses exactly 1 cycle, 1 cycle after iRx_Done. No oTx_Start occurs until iSampling_Finished is applied 100 cycles later; the first oTx_Start follows 3 cycles after it.
- CMD_ABORT during WAIT_SAMPLE -> IDLE next cycle, no oDone. A later iSampling_Finished is ignored.
- CMD_ABORT injected at address 0x0010 while iTx_Busy=1 -> byte 0x10 completes unchanged, no further oTx_Start, no oDone, oBusy drops after NEXT.
- Bytes 0x44 and 0x00 received mid-dump -> ignored; the dump sequence and byte count are unchanged.
